// File: rtl/divider_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: FSM encoding,
// decode funct codes and the default operand width.
package divider_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Decode drives start/signed_div from these funct fields.
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, signs applied on
// completion. The current FSM state is visible as state_q for checkers.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] partial_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             q_neg_q;
  logic             r_neg_q;

  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic             step_ok;
  logic [WIDTH-1:0] partial_d;
  logic [WIDTH-1:0] dividend_d;
  logic [WIDTH-1:0] quotient_d;
  logic [WIDTH-1:0] remainder_d;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  // Dividend register doubles as the quotient shift register.
  always_comb begin
    shifted_d   = {partial_q, dividend_q[WIDTH-1]};
    trial_d     = shifted_d - {1'b0, divisor_q};
    step_ok     = ~trial_d[WIDTH];
    partial_d   = step_ok ? trial_d[WIDTH-1:0] : shifted_d[WIDTH-1:0];
    dividend_d  = {dividend_q[WIDTH-2:0], step_ok};
    quotient_d  = q_neg_q ? -dividend_d : dividend_d;
    remainder_d = r_neg_q ? -partial_d : partial_d;
    mag_a       = (signed_div && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b       = (signed_div && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dividend_q <= mag_a;
            divisor_q  <= mag_b;
            partial_q  <= '0;
            count_q    <= '0;
            q_neg_q    <= signed_div & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            r_neg_q    <= signed_div & operand_a[WIDTH-1];
            if (operand_b == '0) begin
              quotient_q  <= '1;
              remainder_q <= operand_a;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cancel) begin
            state_q <= ST_IDLE;
          end else begin
            partial_q  <= partial_d;
            dividend_q <= dividend_d;
            count_q    <= count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
              quotient_q  <= quotient_d;
              remainder_q <= remainder_d;
              state_q     <= ST_DONE;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: doc/divider.md
Name: divider

Overview:
Multi-cycle radix-2 restoring divider for the MIPS DIV/DIVU instructions. It sits beside the execute stage.
- The execute stage launches it with a one-cycle start pulse and stalls the pipeline while it is busy.
- It consumes the completed quotient and remainder to write HI/LO.
- Writeback of the result to HI/LO is checked through the existing sopc register-dump benches.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clock  input  1  rising-edge system clock (single clock domain)
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
cancel  input  1  flush from exception/branch; aborts an in-flight divide
operand_a  input  WIDTH  dividend (rs)
operand_b  input  WIDTH  divisor (rt)
busy  output  1  high in RUN state
done  output  1  one-cycle pulse; quotient/remainder valid
quotient  output  WIDTH  quotient, for LO
remainder  output  WIDTH  remainder, for HI

Behaviour:
- The reset is synchronous and active-high. One clock, named clock; the reset port is named reset.
- Reset (at any time, including mid-divide) forces:
  - state=IDLE, counter=0, busy=0, done=0
  - quotient=0, remainder=0
  - all internal operand/partial registers=0
- States:
  - IDLE -> RUN: start=1 and operand_b!=0.
  - IDLE -> DONE: start=1 and operand_b==0.
  - RUN -> RUN: counter<WIDTH-1.
  - RUN -> DONE: counter==WIDTH-1.
  - RUN -> IDLE: cancel=1. This has priority over iteration.
  - DONE -> IDLE: unconditionally after one cycle.
- Launch edge:
  - Latch |a| and |b| (magnitudes when signed_div=1, raw values otherwise).
  - Latch the sign of the quotient (sign_a XOR sign_b) and the sign of the remainder (sign_a), both only when signed_div=1.
  - Clear the partial remainder and set counter=0.
- RUN step, each cycle, on WIDTH+1-bit arithmetic:
  - Shift {partial, dividend} left by 1.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and shift in a quotient bit of 1; else shift in 0.
  - counter increments.
- Latency:
  - start at edge k gives RUN for edges k+1..k+WIDTH.
  - At edge k+WIDTH+1, done=1 for exactly one cycle.
  - So done is first visible WIDTH+1 cycles after launch (33 for WIDTH=32).
- Result registers:
  - quotient/remainder update on the edge entering DONE, with signs applied (negate when the latched sign=1).
  - They hold their value until the next completion or reset.
- Divide by zero:
  - No iteration is performed. DONE is entered on the next edge.
  - quotient=all ones, remainder=operand_a (raw).
- Overflow case, signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0, by natural wrap of the negation. No trap is raised.
- start is ignored while in RUN or DONE.
- cancel behaviour:
  - cancel in IDLE or DONE has no effect. A DONE pulse already asserted is not retracted.
  - cancel in RUN: IDLE on the next edge, no done pulse, and quotient/remainder keep their previous values.
- start and cancel both high in IDLE: start wins, because cancel only applies to RUN.
- busy is combinational from state only. done is registered state decode, so it has no combinational path from the inputs.

Decomposition:
- Shared defines file:
  - state encodings IDLE/RUN/DONE (2-bit)
  - the DIV/DIVU funct codes (6'b011010 / 6'b011011) used by decode to drive start/signed_div
  - the WIDTH default
- No sub-module. The single trial-subtract/shift step is inline combinational logic within the divider. The execute-stage stall equation stays in the execute stage.

Test Plan:
- Unsigned: DIVU a=100, b=7, start at cycle 0 -> busy high for cycles 1-32; done at cycle 33 with quotient=0x0000000E, remainder=0x00000002.
- Signed: DIV a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also DIV a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=0x00000001.
- Zero/overflow:
  - a=5, b=0 -> done one cycle after start, busy never high; quotient=0xFFFFFFFF, remainder=0x00000005.
  - Signed a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Cancel: start 1000/3, cancel at RUN cycle 10 -> busy low next cycle, no done, outputs unchanged. A following start of DIVU 9/3 -> done after 33 cycles with quotient=3, remainder=0.
- Ignored start / reset: a second start pulsed during RUN does not disturb the result 0x0000FFFF / 0x10 -> quotient=0x00000FFF, remainder=0xF. A reset asserted at RUN cycle 20 -> next cycle busy=0, done=0, quotient=0, remainder=0.
